// File: rtl/ifetch_pkg.sv
// Shared types and widths for the instruction-fetch unit.
package ifetch_pkg;

   localparam int          ADDR_W       = 16;
   localparam int          INSTR_W      = 16;
   localparam int          DEPTH_DEF    = 2;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO holding {instr, pc} pairs; supports flush and
// simultaneous push/pop (including when full).
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                push,
   input  logic [INSTR_W-1:0]  push_instr,
   input  logic [ADDR_W-1:0]   push_pc,
   input  logic                pop,
   output logic                valid,
   output logic                full,
   output logic [INSTR_W-1:0]  head_instr,
   output logic [ADDR_W-1:0]   head_pc
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_q, wr_d;
   logic [PTR_W-1:0]   rd_q, rd_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               pop_ok;
   logic               push_ok;
   entry_t             head;

   assign valid   = (count_q != '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop & valid;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_q] = '{instr: push_instr, pc: push_pc};
            wr_d        = wr_q + PTR_W'(1);
         end
         if (pop_ok) rd_d = rd_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Empty queue presents zeros rather than stale storage.
   assign head       = valid ? mem_q[rd_q] : '0;
   assign head_instr = head.instr;
   assign head_pc    = head.pc;

endmodule

// File: rtl/ifetch.sv
// Fetch initiator: owns the PC, drives the combinational instruction
// memory and feeds decode through the prefetch queue.
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [15:0] ram_addr,
   input  logic [15:0] ram_dout,
   input  logic        redir_valid,
   input  logic [15:0] redir_pc,
   output logic        if_valid,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   input  logic        id_ready
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              full;
   logic              push;
   logic              pop;

   // Redirect squashes both sides of the queue for this cycle.
   assign pop  = if_valid & id_ready & ~redir_valid;
   assign push = fetch_en & ~redir_valid & (~full | pop);

   always_comb begin
      pc_d = pc_q;
      unique case (1'b1)
         redir_valid: pc_d = redir_pc;
         push:        pc_d = pc_q + 16'd1;
         default:     pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign ram_addr = pc_q;

   ifetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redir_valid),
      .push       (push),
      .push_instr (ram_dout),
      .push_pc    (pc_q),
      .pop        (pop),
      .valid      (if_valid),
      .full       (full),
      .head_instr (if_instr),
      .head_pc    (if_pc)
   );

endmodule

// File: tb/tb_ifetch.sv
// Scenario bench for ifetch: expected {instr, pc} pairs are queued as
// stimulus is applied and compared as the decoder side accepts them.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b1;
   logic [15:0] ram_addr;
   logic [15:0] ram_dout;
   logic        redir_valid = 1'b0;
   logic [15:0] redir_pc = 16'h0000;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        id_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_e;

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0000) return 16'ha861;
      if (a == 16'h0001) return 16'h8463;
      return 16'h0000;
   endfunction

   assign ram_dout = mem_word(ram_addr);

   ifetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_en    (fetch_en),
      .ram_addr    (ram_addr),
      .ram_dout    (ram_dout),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .id_ready    (id_ready)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic rdy);
      @(negedge clk);
      rst_n       = 1'b0;
      fetch_en    = 1'b1;
      redir_valid = 1'b0;
      id_ready    = rdy;
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({if_valid, if_instr, if_pc} !== 33'h0) begin
         miscompares++;
         $display("FAIL reset_out got v=%b i=%h p=%h want 0/0000/0000",
                  if_valid, if_instr, if_pc);
      end
      vectors++;
      if (ram_addr !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_addr got %h want 0000", ram_addr);
      end
   endtask

   task automatic test_stream();
      do_reset(1'b1);
      vectors++;
      if (if_valid !== 1'b0 || ram_addr !== 16'h0000) begin
         miscompares++;
         $display("FAIL stream_c0 got v=%b a=%h want 0/0000", if_valid, ram_addr);
      end
      sb.push_back({16'ha861, 16'h0000});
      sb.push_back({16'h8463, 16'h0001});
      sb.push_back({16'h0000, 16'h0002});
      sb.push_back({16'h0000, 16'h0003});
      for (int k = 0; k < 4; k++) begin
         step();
         exp_e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
         vectors++;
         if (if_valid !== 1'b1 || {if_instr, if_pc} !== exp_e) begin
            miscompares++;
            $display("FAIL stream_out%0d got v=%b %h/%h want 1 %h/%h", k,
                     if_valid, if_instr, if_pc, exp_e[31:16], exp_e[15:0]);
         end
         vectors++;
         if (ram_addr !== 16'(k + 1)) begin
            miscompares++;
            $display("FAIL stream_addr%0d got %h want %h", k, ram_addr, 16'(k + 1));
         end
      end
   endtask

   task automatic test_stall();
      do_reset(1'b0);
      repeat (5) step();
      vectors++;
      if (ram_addr !== 16'h0002 || if_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_hold got a=%h v=%b want 0002 1", ram_addr, if_valid);
      end
      sb.push_back({16'ha861, 16'h0000});
      sb.push_back({16'h8463, 16'h0001});
      sb.push_back({16'h0000, 16'h0002});
      id_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
         vectors++;
         if (if_valid !== 1'b1 || {if_instr, if_pc} !== exp_e) begin
            miscompares++;
            $display("FAIL stall_drain%0d got v=%b %h/%h want 1 %h/%h", k,
                     if_valid, if_instr, if_pc, exp_e[31:16], exp_e[15:0]);
         end
         step();
      end
   endtask

   task automatic test_redirect();
      do_reset(1'b0);
      repeat (2) step();
      id_ready    = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = 16'h0001;
      step();
      redir_valid = 1'b0;
      vectors++;
      if (if_valid !== 1'b0 || ram_addr !== 16'h0001) begin
         miscompares++;
         $display("FAIL redir_flush got v=%b a=%h want 0 0001", if_valid, ram_addr);
      end
      sb.push_back({16'h8463, 16'h0001});
      sb.push_back({16'h0000, 16'h0002});
      for (int k = 0; k < 2; k++) begin
         step();
         exp_e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
         vectors++;
         if (if_valid !== 1'b1 || {if_instr, if_pc} !== exp_e) begin
            miscompares++;
            $display("FAIL redir_out%0d got v=%b %h/%h want 1 %h/%h", k,
                     if_valid, if_instr, if_pc, exp_e[31:16], exp_e[15:0]);
         end
      end
   endtask

   task automatic test_wrap();
      id_ready    = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = 16'hFFFE;
      step();
      redir_valid = 1'b0;
      vectors++;
      if (if_valid !== 1'b0 || ram_addr !== 16'hFFFE) begin
         miscompares++;
         $display("FAIL wrap_flush got v=%b a=%h want 0 fffe", if_valid, ram_addr);
      end
      sb.push_back({16'h0000, 16'hFFFE});
      sb.push_back({16'h0000, 16'hFFFF});
      sb.push_back({16'ha861, 16'h0000});
      sb.push_back({16'h8463, 16'h0001});
      for (int k = 0; k < 4; k++) begin
         step();
         exp_e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
         vectors++;
         if (if_valid !== 1'b1 || {if_instr, if_pc} !== exp_e) begin
            miscompares++;
            $display("FAIL wrap_out%0d got v=%b %h/%h want 1 %h/%h", k,
                     if_valid, if_instr, if_pc, exp_e[31:16], exp_e[15:0]);
         end
      end
   endtask

   task automatic test_fetch_en();
      do_reset(1'b0);
      repeat (2) step();
      fetch_en = 1'b0;
      id_ready = 1'b1;
      sb.push_back({16'ha861, 16'h0000});
      sb.push_back({16'h8463, 16'h0001});
      for (int k = 0; k < 2; k++) begin
         exp_e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
         vectors++;
         if (if_valid !== 1'b1 || {if_instr, if_pc} !== exp_e) begin
            miscompares++;
            $display("FAIL fen_drain%0d got v=%b %h/%h want 1 %h/%h", k,
                     if_valid, if_instr, if_pc, exp_e[31:16], exp_e[15:0]);
         end
         step();
      end
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (if_valid !== 1'b0 || ram_addr !== 16'h0002) begin
            miscompares++;
            $display("FAIL fen_frozen%0d got v=%b a=%h want 0 0002", k,
                     if_valid, ram_addr);
         end
         step();
      end
      fetch_en = 1'b1;
      step();
      vectors++;
      if (if_valid !== 1'b1 || if_pc !== 16'h0002 || ram_addr !== 16'h0003) begin
         miscompares++;
         $display("FAIL fen_resume got v=%b p=%h a=%h want 1 0002 0003",
                  if_valid, if_pc, ram_addr);
      end
   endtask

   task automatic test_async_reset();
      do_reset(1'b1);
      repeat (4) step();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (if_valid !== 1'b0 || ram_addr !== 16'h0000 || if_pc !== 16'h0000) begin
         miscompares++;
         $display("FAIL areset_now got v=%b a=%h p=%h want 0 0000 0000",
                  if_valid, ram_addr, if_pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      sb.push_back({16'ha861, 16'h0000});
      sb.push_back({16'h8463, 16'h0001});
      for (int k = 0; k < 2; k++) begin
         step();
         exp_e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
         vectors++;
         if (if_valid !== 1'b1 || {if_instr, if_pc} !== exp_e) begin
            miscompares++;
            $display("FAIL areset_out%0d got v=%b %h/%h want 1 %h/%h", k,
                     if_valid, if_instr, if_pc, exp_e[31:16], exp_e[15:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_fetch_en();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch initiator for the 16-bit CPU: owns the program counter, drives the address of the combinational instruction memory, captures the returned word each cycle and buffers it in a 2-entry prefetch queue. Presents instructions with their addresses to the decode stage over a valid/ready handshake, and restarts the fetch stream on a branch redirect. Sits between the bench/instruction memory and the decoder.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- DEPTH, 2, prefetch queue entries (power of two, ≥2)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- fetch_en  input  1  1 = fetching allowed; 0 = PC and queue frozen (pops still accepted)
- ram_addr  output  16  instruction memory address (= PC register)
- ram_dout  input  16  instruction word for ram_addr, valid in the same cycle (combinational memory)
- redir_valid  input  1  branch/jump redirect request
- redir_pc  input  16  redirect target
- if_valid  output  1  head of queue holds an instruction
- if_instr  output  16  head instruction word
- if_pc  output  16  address of head instruction
- id_ready  input  1  decoder accepts head this cycle

## Operation
- State: pc (16b), queue of DEPTH entries {instr, pc}, wr_ptr, rd_ptr, count (0..DEPTH).
- Push: when fetch_en=1, no redirect, and (count<DEPTH or pop this cycle): store {ram_dout, pc}, pc <= pc+1.
- Pop: when if_valid & id_ready and no redirect: rd_ptr advances.
- Push and pop in the same cycle allowed, including when full: count unchanged.
- PC arithmetic modulo 2^16: 16'hFFFF + 1 = 16'h0000, no flag, fetch continues.
- Redirect (redir_valid=1) has priority over everything: queue flushed (count=0, pointers reset), pc <= redir_pc, no push and no pop that cycle; a concurrent handshake is discarded (decoder must treat the redirect as squashing it).
- fetch_en=0: no push, pc holds; queue drains via pops; redirect still honored.
- Empty: if_valid=0, if_instr=16'h0000, if_pc=16'h0000.
- Reset (any time, including mid-stream): pc=RESET_PC, queue empty, if_valid=0, if_instr=0, if_pc=0, ram_addr=RESET_PC. In-flight entries are lost.

## Timing
- ram_addr is a register output, glitch-free; memory data sampled at the next rising edge.
- Fetch-to-valid latency: word at address A captured at the edge ending the cycle ram_addr=A; if_valid rises the cycle after.
- After rst_n deasserts: edge 1 captures mem[RESET_PC]; if_valid=1 from cycle 1; queue full after edge 2 if decoder stalls.
- Steady state with id_ready=1: one instruction per cycle, no bubbles.
- Redirect asserted in cycle N: cycle N+1 ram_addr=redir_pc, if_valid=0; cycle N+2 if_valid=1, if_pc=redir_pc.
- id_ready may depend combinationally on if_valid; if_valid/if_instr/if_pc never depend combinationally on id_ready or redir_valid (registered).

## Structure
- Shared package ifetch_pkg: ADDR_W=16, INSTR_W=16, RESET_PC default, queue entry struct {instr, pc}.
- One sub-module: ifetch_queue (synchronous FIFO, DEPTH entries, flush input, simultaneous push/pop); ifetch holds PC, push/pop/redirect control.

## Test plan
- Reset then run with mem[0]=16'ha861, mem[1]=16'h8463, rest 0, id_ready=1 -> ram_addr 0,1,2…; outputs (a861,pc 0),(8463,pc 1),(0000,pc 2) on consecutive cycles after 1-cycle latency.
- id_ready=0 for 5 cycles -> queue holds a861/8463, ram_addr stops at 2, count=2; id_ready=1 -> both delivered in order, no loss or duplicates.
- Redirect to 16'h0001 while queue full and id_ready=1 -> next cycle if_valid=0, ram_addr=1; following cycle if_instr=8463, if_pc=1; stale entries never appear.
- redir_pc=16'hFFFE -> if_pc sequence FFFE, FFFF, 0000 (wrap), if_instr at 0000 = a861.
- fetch_en=0 with queue full -> two pops drain, then if_valid=0, ram_addr frozen; fetch_en=1 resumes at frozen address.
- rst_n pulsed low mid-stream (async, between edges) -> if_valid=0 and ram_addr=RESET_PC immediately; restarts as in scenario 1.
